// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start(0), DATA_W bits LSB first, [parity], stop(1).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [BW-1:0]     bit_r, bit_s;
  logic [DATA_W-1:0] shreg_r, shreg_s;
  logic              tx_out_r, tx_out_s;
  logic              tx_ready_r, tx_ready_s;
  logic              busy_r, busy_s;
  logic              frame_done_r, frame_done_s;
  logic              last_s;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_r, parity_s;
`endif

  // Next-state, counters, shift register and next values of the registered outputs.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    bit_s    = bit_r;
    shreg_s  = shreg_r;
`ifdef SERIAL_TX_PARITY_EN
    parity_s = parity_r;
`endif
    last_s   = (cnt_r == CNT_MAX);

    case (state_r)
      IDLE: begin
        if (tx_valid) begin
          state_s  = START;
          bit_s    = '0;
          shreg_s  = tx_data;
`ifdef SERIAL_TX_PARITY_EN
          parity_s = even_parity(tx_data);
`endif
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (last_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (last_s) begin
          shreg_s = shreg_r >> 1;
          if (bit_r == BIT_MAX) begin
            bit_s = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            bit_s = bit_r + BW'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (last_s) begin
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (last_s) begin
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // The bit-cycle counter only runs while a frame is on the line.
    if (state_r == IDLE) begin
      cnt_s = '0;
    end else if (last_s) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CW'(1);
    end

    case (state_s)
      IDLE:    tx_out_s = 1'b1;
      START:   tx_out_s = 1'b0;
      DATA:    tx_out_s = shreg_s[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  tx_out_s = parity_s;
`endif
      STOP:    tx_out_s = 1'b1;
      default: tx_out_s = 1'b1;
    endcase

    tx_ready_s   = (state_s == IDLE);
    busy_s       = (state_s != IDLE);
    frame_done_s = (state_s == STOP) && (cnt_s == CNT_MAX);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      bit_r        <= '0;
      shreg_r      <= '0;
      tx_out_r     <= 1'b1;
      tx_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_r     <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      bit_r        <= bit_s;
      shreg_r      <= shreg_s;
      tx_out_r     <= tx_out_s;
      tx_ready_r   <= tx_ready_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
`ifdef SERIAL_TX_PARITY_EN
      parity_r     <= parity_s;
`endif
    end
  end

  assign tx_out     = tx_out_r;
  assign tx_ready   = tx_ready_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: driver pushes accepted words, a monitor checks every line cycle.
// The reference model builds each frame from the bit-slot rules (honours SERIAL_TX_PARITY_EN).
module tb_serial_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NSLOT = DW + 3;
`else
  localparam int NSLOT = DW + 2;
`endif
  localparam int FLEN = NSLOT * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready, tx_out, busy, frame_done;

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [31:0]   hs;
  } item_t;

  item_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  logic  rst_q = 1'b0;
  bit    in_frame = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: line level in cycle k of a frame carrying word d.
  function automatic logic exp_line(input logic [DW-1:0] d, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= DW) return d[slot-1];
`ifdef SERIAL_TX_PARITY_EN
    if (slot == DW + 1) return logic'($countones(d) % 2);
`endif
    return 1'b1;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_tx_out"}, tx_out, 1);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Monitor: follows the line cycle by cycle, popping one expected word per frame.
  initial begin : monitor
    bit    armed;
    int    k;
    item_t cur;
    armed = 1'b0;
    k = 0;
    forever begin
      @(negedge clk);
      if (rst_q === 1'b1) begin
        armed    = 1'b1;
        in_frame = 1'b0;
        chk_idle("reset");
      end else if (armed) begin
        if (!in_frame && busy === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            chk("start_latency", cyc, cur.hs + 1);
            in_frame = 1'b1;
            k = 0;
          end
        end
        if (in_frame) begin
          if (k < FLEN) begin
            chk("line_bit", tx_out, exp_line(cur.data, k));
            chk("frame_done", frame_done, (k == FLEN - 1) ? 1 : 0);
            chk("busy", busy, 1);
            chk("tx_ready", tx_ready, 0);
            k++;
          end else begin
            chk_idle("gap");
            in_frame = 1'b0;
          end
        end else if (busy !== 1'b1) begin
          chk_idle("idle");
        end
      end
    end
  end

  // Drive one word; call at a negedge. Returns at the negedge after the handshake.
  task automatic send(input logic [DW-1:0] d, input bit hold, input logic [DW-1:0] scr,
                      output int hs);
    logic rdy;
    int   hc;
    bit   done;
    done = 1'b0;
    hs = -1;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int n = 0; n < 4 * FLEN && !done; n++) begin
      rdy = tx_ready;
      hc  = cyc;
      @(posedge clk);
      if (rdy === 1'b1 && reset !== 1'b1) begin
        exp_q.push_back('{data: d, hs: hc});
        hs   = hc;
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) chk("handshake_timeout", 0, 1);
    tx_data = scr;
    if (!hold || !done) tx_valid = 1'b0;
  endtask

  initial begin : stim
    int h1, h2, hx;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    send(8'hA5, 1'b0, 8'h00, hx);
    repeat (FLEN + 2) @(negedge clk);

    // Back-to-back with valid held: exactly one idle cycle between frames.
    send(8'h00, 1'b1, 8'h55, h1);
    send(8'hFF, 1'b0, 8'h00, h2);
    chk("b2b_spacing", h2 - h1, FLEN + 1);
    repeat (FLEN + 2) @(negedge clk);

    // Input changes during the frame must not reach the line.
    send(8'h3C, 1'b0, 8'hFF, hx);
    repeat (FLEN + 2) @(negedge clk);

    // Reset during data bit 3 aborts the frame.
    send(8'h5A, 1'b0, 8'h00, hx);
    repeat (4 * CPB + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", tx_ready, 1);
    send(8'h81, 1'b0, 8'h00, hx);
    repeat (FLEN + 2) @(negedge clk);

    // Reset wins over a same-cycle tx_valid.
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    @(negedge clk);
    reset    = 1'b0;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_vs_valid_busy", busy, 0);

    send(8'hA5, 1'b0, 8'h00, hx);
    send(8'h07, 1'b0, 8'h00, hx);

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(DW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom), hx);
    end
    tx_valid = 1'b0;

    for (int n = 0; n < 4 * FLEN && (exp_q.size() != 0 || in_frame); n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain", exp_q.size() + int'(in_frame), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
